// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin write sequencer for a bank of NAND SR latches.
// Define SR_LATCH_CTRL_INIT_EN to clear every latch (Q=0) after reset.
module sr_latch_ctrl #(
    parameter int NCH = 4,
    parameter int PW  = 2,
    parameter int ST  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         set_req,
    input  logic [NCH-1:0]         rst_req,
    input  logic [NCH-1:0]         q_in,
    input  logic                   err_clr,
    output logic [NCH-1:0]         sbar,
    output logic [NCH-1:0]         rbar,
    output logic [NCH-1:0]         ack,
    output logic                   busy,
    output logic                   err,
    output logic [$clog2(NCH)-1:0] err_ch
);

    localparam int CW   = $clog2(NCH);
    localparam int CMAX = ((PW > ST) ? PW : ST) + 2;
    localparam int NW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3
`ifdef SR_LATCH_CTRL_INIT_EN
        ,
        INIT   = 3'd4
`endif
    } state_t;

    state_t          r_state;
    logic [NW-1:0]   r_cnt;
    logic [CW-1:0]   r_gch;
    logic            r_op;
    logic [CW-1:0]   r_rr;
    logic [NCH-1:0]  r_sbar;
    logic [NCH-1:0]  r_rbar;
    logic [NCH-1:0]  r_ack;
    logic            r_busy;
    logic            r_err;
    logic [CW-1:0]   r_err_ch;

    state_t          w_state_n;
    logic [NW-1:0]   w_cnt_n;
    logic [CW-1:0]   w_gch_n;
    logic            w_op_n;
    logic [CW-1:0]   w_rr_n;
    logic            w_err_n;
    logic [CW-1:0]   w_err_ch_n;
    logic [NCH-1:0]  w_sbar_n;
    logic [NCH-1:0]  w_rbar_n;
    logic [NCH-1:0]  w_ack_n;
    logic            w_busy_n;

    logic [NCH-1:0]  w_pend;
    logic            w_found;
    logic [CW-1:0]   w_pick;
    logic            w_mis;

    assign w_pend = set_req | rst_req;
    // r_op is 1 for a reset write, so the expected Q is its inverse
    assign w_mis  = (q_in[r_gch] != ~r_op);

    // First pending channel at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (int'(r_rr) + k) % NCH;
            if (!w_found && w_pend[idx]) begin
                w_found = 1'b1;
                w_pick  = CW'(idx);
            end
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_gch_n    = r_gch;
        w_op_n     = r_op;
        w_rr_n     = r_rr;
        w_err_n    = err_clr ? 1'b0 : r_err;
        w_err_ch_n = r_err_ch;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n = PULSE;
                    w_cnt_n   = '0;
                    w_gch_n   = w_pick;
                    w_op_n    = rst_req[w_pick];
                end
            end
            PULSE: begin
                if (r_cnt == NW'(PW - 1)) begin
                    w_state_n = (ST == 0) ? CHECK : SETTLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + NW'(1);
                end
            end
            SETTLE: begin
                if (r_cnt == NW'(ST - 1)) begin
                    w_state_n = CHECK;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + NW'(1);
                end
            end
            CHECK: begin
                if (w_mis) begin
                    w_err_n    = 1'b1;
                    w_err_ch_n = r_gch;
                end
                w_rr_n    = (r_gch == CW'(NCH - 1)) ? '0 : r_gch + CW'(1);
                w_state_n = IDLE;
            end
`ifdef SR_LATCH_CTRL_INIT_EN
            INIT: begin
                if (r_cnt == NW'(PW + 1)) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + NW'(1);
                end
            end
`endif
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered copies of what the next state drives
    always_comb begin
        w_sbar_n = '1;
        w_rbar_n = '1;
        w_ack_n  = '0;
        w_busy_n = 1'b0;
        unique case (w_state_n)
            PULSE: begin
                w_busy_n = 1'b1;
                if (w_op_n) begin
                    w_rbar_n[w_gch_n] = 1'b0;
                end else begin
                    w_sbar_n[w_gch_n] = 1'b0;
                end
            end
            SETTLE: begin
                w_busy_n = 1'b1;
            end
            CHECK: begin
                w_busy_n         = 1'b1;
                w_ack_n[w_gch_n] = 1'b1;
            end
`ifdef SR_LATCH_CTRL_INIT_EN
            INIT: begin
                w_busy_n = 1'b1;
                if (w_cnt_n <= NW'(PW)) begin
                    w_rbar_n = '0;
                end
            end
`endif
            default: begin
                w_busy_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef SR_LATCH_CTRL_INIT_EN
            r_state  <= INIT;
`else
            r_state  <= IDLE;
`endif
            r_cnt    <= '0;
            r_gch    <= '0;
            r_op     <= 1'b0;
            r_rr     <= '0;
            r_sbar   <= '1;
            r_rbar   <= '1;
            r_ack    <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_err_ch <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_gch    <= w_gch_n;
            r_op     <= w_op_n;
            r_rr     <= w_rr_n;
            r_sbar   <= w_sbar_n;
            r_rbar   <= w_rbar_n;
            r_ack    <= w_ack_n;
            r_busy   <= w_busy_n;
            r_err    <= w_err_n;
            r_err_ch <= w_err_ch_n;
        end
    end

    assign sbar   = r_sbar;
    assign rbar   = r_rbar;
    assign ack    = r_ack;
    assign busy   = r_busy;
    assign err    = r_err;
    assign err_ch = r_err_ch;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: directed bench with an SR latch model and an ack scoreboard.
// Also covers the SR_LATCH_CTRL_INIT_EN build when that macro is defined.
module tb_sr_latch_ctrl;

    localparam int NCH = 4;
    localparam int PW  = 2;
    localparam int ST  = 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] set_req = '0;
    logic [NCH-1:0] rst_req = '0;
    logic [NCH-1:0] q_in;
    logic           err_clr = 1'b0;
    logic [NCH-1:0] sbar;
    logic [NCH-1:0] rbar;
    logic [NCH-1:0] ack;
    logic           busy;
    logic           err;
    logic [1:0]     err_ch;

    typedef struct packed {
        logic [NCH-1:0] a;
        logic           e_err;
        logic [1:0]     e_ch;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    logic [NCH-1:0] lq = '0;
    logic [NCH-1:0] stuck_m = '0;
    logic [NCH-1:0] stuck_v = '0;

    sr_latch_ctrl #(.NCH(NCH), .PW(PW), .ST(ST)) dut (
        .clk(clk), .reset(reset), .set_req(set_req), .rst_req(rst_req),
        .q_in(q_in), .err_clr(err_clr), .sbar(sbar), .rbar(rbar),
        .ack(ack), .busy(busy), .err(err), .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    // Latch bank model with optional stuck-at readback faults
    assign q_in = (lq & ~stuck_m) | (stuck_v & stuck_m);
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!sbar[i]) lq[i] <= 1'b1;
            else if (!rbar[i]) lq[i] <= 1'b0;
        end
    end

    task automatic chkv(input string tag, input logic [NCH-1:0] obs,
                        input logic [NCH-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chkv("never_both_low", sbar | rbar, '1);
`ifndef SR_LATCH_CTRL_INIT_EN
            chki("one_strobe",
                 int'(($countones(~sbar) + $countones(~rbar)) <= 1), 1);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NCH-1:0] a, input logic e,
                        input logic [1:0] ch);
        exp_t x;
        x.a    = a;
        x.e_err = e;
        x.e_ch = ch;
        sbq.push_back(x);
    endtask

    // Waits (bounded) for an ack, then compares it against the scoreboard
    task automatic wait_ack(input string tag, input int lat_exp,
                            output exp_t e);
        int lat;
        lat = 0;
        while (ack === '0 && lat < 40) begin
            tick();
            lat++;
        end
        if (sbq.size() == 0) begin
            chki({tag, "_sb_empty"}, 1, 0);
            e = '0;
        end else begin
            e = sbq.pop_front();
            chkv({tag, "_ack"}, ack, e.a);
            chki({tag, "_lat"}, lat, lat_exp);
        end
    endtask

    task automatic post(input string tag, input exp_t e);
        tick();
        chki({tag, "_err"}, int'(err), int'(e.e_err));
        chki({tag, "_errch"}, int'(err_ch), int'(e.e_ch));
        chki({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        set_req = '0;
        rst_req = '0;
        err_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
`ifdef SR_LATCH_CTRL_INIT_EN
        repeat (PW + 2) tick();
`endif
    endtask

    initial begin
        exp_t e;
        int   acks;

        // Reset values
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        chkv("rst_sbar", sbar, '1);
        chkv("rst_rbar", rbar, '1);
        chkv("rst_ack", ack, '0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_err", int'(err), 0);
        chki("rst_errch", int'(err_ch), 0);

`ifdef SR_LATCH_CTRL_INIT_EN
        set_req = 4'b0100;
        push(4'b0100, 1'b0, 2'd0);
        tick();
        chkv("init_rbar_c1", rbar, 4'b0000);
        chki("init_busy_c1", int'(busy), 1);
        tick();
        chkv("init_rbar_c2", rbar, 4'b0000);
        tick();
        chkv("init_rbar_c3", rbar, '1);
        chki("init_busy_c3", int'(busy), 1);
        chkv("init_sbar_c3", sbar, '1);
        tick();
        chki("init_busy_c4", int'(busy), 0);
        chkv("init_sbar_c4", sbar, '1);
        tick();
        chkv("init_grant", sbar, 4'b1011);
        set_req = '0;
        wait_ack("init_req", 3, e);
        post("init_req", e);
        do_reset();
`else
        tick();
        chki("idle_stays", int'(busy), 0);
`endif

        // Single SET on channel 2, cycle by cycle
        set_req = 4'b0100;
        push(4'b0100, 1'b0, 2'd0);
        tick();
        set_req = '0;
        chkv("t1_sbar_c1", sbar, 4'b1011);
        chkv("t1_rbar_c1", rbar, '1);
        chki("t1_busy_c1", int'(busy), 1);
        tick();
        chkv("t1_sbar_c2", sbar, 4'b1011);
        tick();
        chkv("t1_sbar_c3", sbar, '1);
        chki("t1_busy_c3", int'(busy), 1);
        wait_ack("t1", 1, e);
        post("t1", e);

        // Round robin over 1011 with ch0 re-raised: 0,1,3,0, acks 5 apart
        do_reset();
        set_req = 4'b1011;
        push(4'b0001, 1'b0, 2'd0);
        wait_ack("rr0", PW + ST + 1, e);
        set_req[0] = 1'b0;
        push(4'b0010, 1'b0, 2'd0);
        post("rr0", e);
        wait_ack("rr1", PW + ST + 1, e);
        set_req[1] = 1'b0;
        set_req[0] = 1'b1;
        push(4'b1000, 1'b0, 2'd0);
        post("rr1", e);
        wait_ack("rr3", PW + ST + 1, e);
        set_req[3] = 1'b0;
        push(4'b0001, 1'b0, 2'd0);
        post("rr3", e);
        wait_ack("rr0b", PW + ST + 1, e);
        set_req[0] = 1'b0;
        post("rr0b", e);

        // Set and reset together on channel 1: reset wins
        do_reset();
        set_req = 4'b0010;
        rst_req = 4'b0010;
        push(4'b0010, 1'b0, 2'd0);
        tick();
        set_req = '0;
        rst_req = '0;
        chkv("t3_rbar_c1", rbar, 4'b1101);
        chkv("t3_sbar_c1", sbar, '1);
        tick();
        chkv("t3_rbar_c2", rbar, 4'b1101);
        chkv("t3_sbar_c2", sbar, '1);
        wait_ack("t3", 2, e);
        post("t3", e);

        // Reset on channel 3 whose Q is stuck at 1
        stuck_m = 4'b1000;
        stuck_v = 4'b1000;
        rst_req = 4'b1000;
        push(4'b1000, 1'b1, 2'd3);
        tick();
        rst_req = '0;
        wait_ack("t4", 3, e);
        post("t4", e);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chki("t4_err_clr", int'(err), 0);

        // Mismatch on channel 1 in the same cycle as err_clr
        stuck_m = 4'b0010;
        stuck_v = 4'b0000;
        set_req = 4'b0010;
        push(4'b0010, 1'b1, 2'd1);
        tick();
        set_req = '0;
        wait_ack("t4b", 3, e);
        err_clr = 1'b1;
        post("t4b", e);
        err_clr = 1'b0;
        stuck_m = '0;

        // Reset during the first pulse cycle aborts without ack
        do_reset();
        set_req = 4'b0001;
        tick();
        set_req = '0;
        chkv("t5_sbar_c1", sbar, 4'b1110);
        reset = 1'b1;
        tick();
        chkv("t5_sbar", sbar, '1);
        chkv("t5_rbar", rbar, '1);
        chkv("t5_ack", ack, '0);
        chki("t5_busy", int'(busy), 0);
        reset = 1'b0;
        acks  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack !== '0) acks++;
        end
        chki("t5_no_ack", acks, 0);
        chki("sb_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
